// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes and instruction field bit positions.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// ID/EX pipeline boundary bundle: the decode stage drives it, the EX stage consumes it.
interface id_stage_pipe_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  valid;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic [DATA_W-1:0]     imm;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [5:0]            opcode;
  logic [5:0]            func;

  modport master (
    output valid, rs_data, rt_data, imm, rs, rt, rd, opcode, func
  );

  modport slave (
    input valid, rs_data, rt_data, imm, rs, rt, rd, opcode, func
  );
endinterface

// File: rtl/id_hazard_unit.sv
// Decode-stage stall generation: load-use and branch-operand hazards.
// With BRANCH_FWD_EN defined, MEM-stage producers are forwarded and never stall.
module id_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  if_valid_i,
  input  logic                  is_branch_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic                  ex_we_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_we_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  output logic                  stall_o
);

  // A producer targeting r0 never creates a dependency.
  function automatic logic dst_hit(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] a,
                                   input logic [REG_ADDR_W-1:0] b);
    return (dst != '0) && ((dst == a) || (dst == b));
  endfunction

  logic load_use;
  logic br_on_ex;
  logic br_on_mem;

  assign load_use = ex_mem_read_i && dst_hit(ex_rd_i, rs_i, rt_i);
  assign br_on_ex = is_branch_i && ex_we_i && dst_hit(ex_rd_i, rs_i, rt_i);

`ifdef BRANCH_FWD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_we_i, mem_rd_i};
  assign br_on_mem  = 1'b0;
`else
  assign br_on_mem = is_branch_i && mem_we_i && dst_hit(mem_rd_i, rs_i, rt_i);
`endif

  assign stall_o = if_valid_i && (load_use || br_on_ex || br_on_mem);

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: bypassed register file, sign extension, early BEQ/BNE resolution,
// hazard stalls and the ID/EX register. Optional macro BRANCH_FWD_EN forwards mem_data.
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned IMM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic                  id_flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_we,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target,
  id_stage_pipe_if.master       id_ex
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [5:0]            opcode;
    logic [5:0]            func;
  } id_ex_t;

  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [5:0]            opcode, func;
  logic [DATA_W-1:0]     imm_ext;

  assign rs      = REG_ADDR_W'(instruction[RS_MSB:RS_LSB]);
  assign rt      = REG_ADDR_W'(instruction[RT_MSB:RT_LSB]);
  assign rd      = REG_ADDR_W'(instruction[RD_MSB:RD_LSB]);
  assign opcode  = instruction[OP_MSB:OP_LSB];
  assign func    = instruction[FUNCT_MSB:FUNCT_LSB];
  assign imm_ext = DATA_W'($signed(instruction[IMM_W-1:0]));

  // Register file; entry 0 is never written so it stays at its reset value of zero.
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  always_comb begin
    rf_d = rf_q;
    if (wb_we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_addr == REG_ADDR_W'(i)) rf_d[i] = wb_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads of r0 or out-of-range indices fall through to zero; in-range reads see WB data.
  logic [DATA_W-1:0] rs_val, rt_val;

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs == REG_ADDR_W'(i)) rs_val = (wb_we && wb_addr == rs) ? wb_data : rf_q[i];
      if (rt == REG_ADDR_W'(i)) rt_val = (wb_we && wb_addr == rt) ? wb_data : rf_q[i];
    end
  end

  logic [DATA_W-1:0] cmp_rs, cmp_rt;

`ifdef BRANCH_FWD_EN
  assign cmp_rs = (mem_we && mem_rd == rs && rs != '0) ? mem_data : rs_val;
  assign cmp_rt = (mem_we && mem_rd == rt && rt != '0) ? mem_data : rt_val;
`else
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data;
  assign cmp_rs = rs_val;
  assign cmp_rt = rt_val;
`endif

  logic is_branch;
  logic branch_cond;

  assign is_branch     = is_branch_op(opcode);
  assign branch_cond   = (opcode == OP_BEQ) ? (cmp_rs == cmp_rt) : (cmp_rs != cmp_rt);
  assign branch_taken  = if_valid && is_branch && !stall && !id_flush && branch_cond;
  assign branch_target = pc_plus4 + (imm_ext << 2);

  id_hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .if_valid_i   (if_valid),
    .is_branch_i  (is_branch),
    .rs_i         (rs),
    .rt_i         (rt),
    .ex_we_i      (ex_we),
    .ex_mem_read_i(ex_mem_read),
    .ex_rd_i      (ex_rd),
    .mem_we_i     (mem_we),
    .mem_rd_i     (mem_rd),
    .stall_o      (stall)
  );

  id_ex_t id_ex_d, id_ex_q;

  // Any of stall, flush or an empty IF/ID slot loads an all-zero bubble.
  always_comb begin
    id_ex_d = '0;
    if (if_valid && !stall && !id_flush) begin
      id_ex_d.valid   = 1'b1;
      id_ex_d.rs_data = rs_val;
      id_ex_d.rt_data = rt_val;
      id_ex_d.imm     = imm_ext;
      id_ex_d.rs      = rs;
      id_ex_d.rt      = rt;
      id_ex_d.rd      = rd;
      id_ex_d.opcode  = opcode;
      id_ex_d.func    = func;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign id_ex.valid   = id_ex_q.valid;
  assign id_ex.rs_data = id_ex_q.rs_data;
  assign id_ex.rt_data = id_ex_q.rt_data;
  assign id_ex.imm     = id_ex_q.imm;
  assign id_ex.rs      = id_ex_q.rs;
  assign id_ex.rt      = id_ex_q.rt;
  assign id_ex.rd      = id_ex_q.rd;
  assign id_ex.opcode  = id_ex_q.opcode;
  assign id_ex.func    = id_ex_q.func;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; expectations follow BRANCH_FWD_EN.
module tb_id_stage_pipe;
  import mips_pkg::*;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  if_valid, id_flush, wb_we, ex_we, ex_mem_read, mem_we;
  logic [31:0]           instruction;
  logic [DATA_W-1:0]     pc_plus4, wb_data, mem_data;
  logic [REG_ADDR_W-1:0] wb_addr, ex_rd, mem_rd;
  logic                  stall, branch_taken;
  logic [DATA_W-1:0]     branch_target;

  int checks = 0;
  int errors = 0;

  id_stage_pipe_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) id_ex ();

  id_stage_pipe #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_REGS(32), .IMM_W(16)
  ) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
    .pc_plus4(pc_plus4), .id_flush(id_flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_we(ex_we), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .id_ex(id_ex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic idle();
    if_valid = 0; id_flush = 0; wb_we = 0; ex_we = 0; ex_mem_read = 0; mem_we = 0;
    instruction = '0; pc_plus4 = '0; wb_data = '0; mem_data = '0;
    wb_addr = '0; ex_rd = '0; mem_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    if_valid = 0; wb_we = 1; wb_addr = a; wb_data = d;
    step();
    wb_we = 0;
  endtask

  task automatic test_reset();
    idle();
    step(); step();
    checks++; if (id_ex.valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b expected 0", id_ex.valid); end
    checks++; if (id_ex.imm !== 32'h0) begin errors++;
      $display("FAIL reset_imm: got %h expected 0", id_ex.imm); end
    rst = 0;
    wb_write(5'd1, 32'h11);
    if_valid = 1; instruction = enc_r(5'd1, 5'd1, 5'd2, 6'h20);
    step();
    checks++; if (id_ex.rs_data !== 32'h11) begin errors++;
      $display("FAIL pre_reset_rs_data: got %h expected 00000011", id_ex.rs_data); end
    #2; rst = 1; #1;
    checks++; if (id_ex.valid !== 1'b0 || id_ex.rs_data !== 32'h0 || id_ex.rd !== 5'd0 ||
                  id_ex.func !== 6'h0) begin errors++;
      $display("FAIL async_reset_clear: got valid=%b rs_data=%h rd=%0d func=%h expected all 0",
               id_ex.valid, id_ex.rs_data, id_ex.rd, id_ex.func); end
    rst = 0;
    step();
    checks++; if (id_ex.valid !== 1'b1 || id_ex.rs_data !== 32'h0) begin errors++;
      $display("FAIL reset_cleared_rf: got valid=%b rs_data=%h expected 1/0",
               id_ex.valid, id_ex.rs_data); end
    idle();
  endtask

  task automatic test_bypass();
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    if_valid = 1; instruction = enc_r(5'd5, 5'd0, 5'd7, 6'h20);
    step();
    checks++; if (id_ex.rs_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL bypass_rs_data: got %h expected deadbeef", id_ex.rs_data); end
    checks++; if (id_ex.valid !== 1'b1 || id_ex.rd !== 5'd7 || id_ex.func !== 6'h20) begin
      errors++; $display("FAIL bypass_fields: got valid=%b rd=%0d func=%h expected 1/7/20",
                         id_ex.valid, id_ex.rd, id_ex.func); end
    wb_addr = 5'd0; wb_data = 32'h123;
    instruction = enc_r(5'd0, 5'd5, 5'd8, 6'h22);
    step();
    checks++; if (id_ex.rs_data !== 32'h0) begin errors++;
      $display("FAIL r0_bypass: got %h expected 0", id_ex.rs_data); end
    checks++; if (id_ex.rt_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL r5_stored: got %h expected deadbeef", id_ex.rt_data); end
    wb_we = 0;
    step();
    checks++; if (id_ex.rs_data !== 32'h0) begin errors++;
      $display("FAIL r0_after_write: got %h expected 0", id_ex.rs_data); end
    idle();
  endtask

  task automatic test_imm();
    if_valid = 1; instruction = enc_i(6'h08, 5'd5, 5'd9, 16'h8001);
    step();
    checks++; if (id_ex.imm !== 32'hFFFF8001 || id_ex.opcode !== 6'h08 || id_ex.rt !== 5'd9)
    begin errors++; $display("FAIL imm_neg: got imm=%h op=%h rt=%0d expected ffff8001/08/9",
                             id_ex.imm, id_ex.opcode, id_ex.rt); end
    instruction = enc_i(6'h08, 5'd5, 5'd9, 16'h7FFF);
    step();
    checks++; if (id_ex.imm !== 32'h00007FFF) begin errors++;
      $display("FAIL imm_pos: got %h expected 00007fff", id_ex.imm); end
    idle();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_we = 1; ex_rd = 5'd3;
    if_valid = 1; instruction = enc_r(5'd1, 5'd3, 5'd4, 6'h20);
    #1;
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL load_use_stall: got %b expected 1", stall); end
    step();
    checks++; if (id_ex.valid !== 1'b0 || id_ex.rt !== 5'd0) begin errors++;
      $display("FAIL load_use_bubble: got valid=%b rt=%0d expected 0/0", id_ex.valid, id_ex.rt);
    end
    ex_mem_read = 0; ex_we = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL load_use_release: got %b expected 0", stall); end
    step();
    checks++; if (id_ex.valid !== 1'b1 || id_ex.rt !== 5'd3) begin errors++;
      $display("FAIL load_use_issue: got valid=%b rt=%0d expected 1/3", id_ex.valid, id_ex.rt); end
    ex_mem_read = 1; ex_rd = 5'd0; instruction = enc_r(5'd0, 5'd0, 5'd4, 6'h20);
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL load_use_r0: got %b expected 0", stall); end
    ex_rd = 5'd3; instruction = enc_r(5'd3, 5'd1, 5'd4, 6'h20); if_valid = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL load_use_invalid: got %b expected 0", stall); end
    idle();
  endtask

  task automatic test_branch();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    if_valid = 1; pc_plus4 = 32'hFFFF_FFFC; instruction = enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0001);
    #1;
    checks++; if (branch_taken !== 1'b1 || branch_target !== 32'h0) begin errors++;
      $display("FAIL beq_wrap: got taken=%b target=%h expected 1/00000000",
               branch_taken, branch_target); end
    instruction = enc_i(OP_BNE, 5'd1, 5'd2, 16'h0001);
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++;
      $display("FAIL bne_equal: got %b expected 0", branch_taken); end
    pc_plus4 = 32'h100; instruction = enc_i(OP_BNE, 5'd1, 5'd3, 16'hFFFF);
    #1;
    checks++; if (branch_taken !== 1'b1 || branch_target !== 32'h0FC) begin errors++;
      $display("FAIL bne_back: got taken=%b target=%h expected 1/000000fc",
               branch_taken, branch_target); end
    instruction = enc_i(OP_BEQ, 5'd1, 5'd3, 16'hFFFF);
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++;
      $display("FAIL beq_differ: got %b expected 0", branch_taken); end
    ex_we = 1; ex_rd = 5'd2; instruction = enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0001);
    #1;
    checks++; if (stall !== 1'b1 || branch_taken !== 1'b0) begin errors++;
      $display("FAIL branch_on_ex: got stall=%b taken=%b expected 1/0", stall, branch_taken); end
    instruction = enc_r(5'd1, 5'd2, 5'd4, 6'h20);
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL alu_on_ex: got %b expected 0", stall); end
    idle();
  endtask

  task automatic test_branch_mem();
    logic exp_stall, exp_taken;
`ifdef BRANCH_FWD_EN
    exp_stall = 1'b0; exp_taken = 1'b1;
`else
    exp_stall = 1'b1; exp_taken = 1'b0;
`endif
    wb_write(5'd6, 32'd9);
    if_valid = 1; mem_we = 1; mem_rd = 5'd4; mem_data = 32'd9;
    instruction = enc_i(OP_BEQ, 5'd4, 5'd6, 16'h0004);
    #1;
    checks++; if (stall !== exp_stall || branch_taken !== exp_taken) begin errors++;
      $display("FAIL branch_on_mem: got stall=%b taken=%b expected %b/%b",
               stall, branch_taken, exp_stall, exp_taken); end
    mem_we = 0; wb_we = 1; wb_addr = 5'd4; wb_data = 32'd9;
    #1;
    checks++; if (stall !== 1'b0 || branch_taken !== 1'b1) begin errors++;
      $display("FAIL branch_via_wb: got stall=%b taken=%b expected 0/1", stall, branch_taken);
    end
    wb_we = 0; mem_we = 1; instruction = enc_r(5'd4, 5'd6, 5'd7, 6'h20);
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL alu_on_mem: got %b expected 0", stall); end
    idle();
  endtask

  task automatic test_flush_stall();
    if_valid = 1; id_flush = 1; ex_mem_read = 1; ex_rd = 5'd3;
    instruction = enc_i(OP_BNE, 5'd1, 5'd3, 16'h0002);
    #1;
    checks++; if (stall !== 1'b1 || branch_taken !== 1'b0) begin errors++;
      $display("FAIL flush_stall_comb: got stall=%b taken=%b expected 1/0", stall, branch_taken);
    end
    step();
    checks++; if (id_ex.valid !== 1'b0) begin errors++;
      $display("FAIL flush_stall_bubble: got %b expected 0", id_ex.valid); end
    ex_mem_read = 0; instruction = enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0002);
    #1;
    checks++; if (stall !== 1'b0 || branch_taken !== 1'b0) begin errors++;
      $display("FAIL flush_branch: got stall=%b taken=%b expected 0/0", stall, branch_taken); end
    step();
    checks++; if (id_ex.valid !== 1'b0) begin errors++;
      $display("FAIL flush_bubble: got %b expected 0", id_ex.valid); end
    id_flush = 0; instruction = enc_r(5'd1, 5'd2, 5'd9, 6'h24);
    step();
    checks++; if (id_ex.valid !== 1'b1 || id_ex.rs_data !== 32'd7) begin errors++;
      $display("FAIL post_flush_issue: got valid=%b rs_data=%h expected 1/7",
               id_ex.valid, id_ex.rs_data); end
    ex_mem_read = 1; ex_rd = 5'd1;
    #2; rst = 1; #1;
    checks++; if (id_ex.valid !== 1'b0 || id_ex.rs_data !== 32'h0 || stall !== 1'b1) begin
      errors++; $display("FAIL reset_mid_stall: got valid=%b rs_data=%h stall=%b expected 0/0/1",
                         id_ex.valid, id_ex.rs_data, stall); end
    rst = 0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_imm();
    test_load_use();
    test_branch();
    test_branch_mem();
    test_flush_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline. It contains the register file with write-through bypass, immediate sign-extension, branch-target adder and an early branch comparator (BEQ/BNE). It adds load-use and branch-operand hazard detection with stall generation, and a registered ID/EX pipeline boundary with bubble insertion and flush. It sits between the IF/ID register and the EX stage.

Parameters:
DATA_W, 32, datapath width (register, PC, immediate-extended width)
REG_ADDR_W, 5, register index width
NUM_REGS, 32, register count; must be ≤ 2**REG_ADDR_W; register 0 reads as zero
IMM_W, 16, immediate field width taken from instruction[IMM_W-1:0]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  IF/ID holds a valid instruction
instruction  in  32  instruction from IF/ID
pc_plus4  in  DATA_W  PC+4 from IF/ID
id_flush  in  1  kill the current ID instruction (insert bubble)
wb_we  in  1  write-back enable
wb_addr  in  REG_ADDR_W  write-back register
wb_data  in  DATA_W  write-back data
ex_we, ex_mem_read  in  1 each  EX-stage instruction writes a register / is a load
ex_rd  in  REG_ADDR_W  EX-stage destination
mem_we  in  1  MEM-stage instruction writes a register
mem_rd  in  REG_ADDR_W  MEM-stage destination
mem_data  in  DATA_W  MEM-stage result (used only with BRANCH_FWD_EN)
stall  out  1  hold PC and IF/ID this cycle
branch_taken  out  1  redirect fetch to branch_target
branch_target  out  DATA_W  pc_plus4 + (imm_ext << 2)
id_ex_valid  out  1  registered: ID/EX holds a real instruction
id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  DATA_W each  registered operands / sign-extended immediate
id_ex_rs, id_ex_rt, id_ex_rd  out  REG_ADDR_W each  registered register indices
id_ex_opcode, id_ex_func  out  6 each  registered instruction[31:26], instruction[5:0]

Behaviour:
- Fields: rs=[25:21], rt=[20:16], rd=[15:11]; indices zero-extended or truncated to REG_ADDR_W.
- Register file: write on rising clk when wb_we && wb_addr!=0. Reads are combinational with same-cycle bypass (wb_we && wb_addr==read_addr && read_addr!=0 yields wb_data). Index 0 or ≥NUM_REGS reads 0.
- imm_ext: sign extension of instruction[IMM_W-1:0] to DATA_W. Branch target arithmetic is modulo 2**DATA_W (wraps).
- Branch: opcode 6'h04 BEQ (taken if rs_val==rt_val), 6'h05 BNE (taken if different). branch_taken = if_valid && is_branch && !stall && !id_flush. Combinational, zero latency.
- Hazards, combinational (a reference to register 0 never stalls):
  - Load-use: ex_mem_read && ex_rd∈{rs,rt}.
  - Branch-on-EX: is_branch && ex_we && ex_rd∈{rs,rt}.
  - Branch-on-MEM: is_branch && mem_we && mem_rd∈{rs,rt}. This case applies only when BRANCH_FWD_EN is undefined.
  - stall asserts for any of the above while if_valid.
- ID/EX register (1-cycle latency), on rising clk:
  - If stall, id_flush or !if_valid: id_ex_valid←0 and all other id_ex_* ←0 (bubble).
  - Otherwise: id_ex_valid←1 and the fields capture the decoded values.
- Simultaneous id_flush and stall: flush wins for the bubble; stall still asserts.
- Reset: asynchronous. All id_ex_* ←0 and all registers ←0. Combinational outputs follow from the zeroed state; stall, branch_taken and branch_target depend only on inputs. Reset mid-stall clears everything immediately.

Optional Feature:
BRANCH_FWD_EN
- Defined: comparator operands are forwarded from mem_data when mem_we && mem_rd matches a nonzero rs/rt. Branch-on-MEM does not stall.
- Undefined: no forwarding mux; Branch-on-MEM stalls one cycle and the value arrives via WB bypass.

Decomposition:
- mips_pkg: opcode constants (OP_BEQ=6'h04, OP_BNE=6'h05, OP_RTYPE=6'h00), field bit positions.
- One sub-module id_hazard_unit: all stall logic, taking rs, rt, is_branch and the EX/MEM control inputs.
- The register file stays inline, using the existing reg_file style plus the bypass.

Test Plan:
- Reset with rst=1 mid-run: all id_ex_* =0 and r1..r31 read 0 in the same cycle, before the next clk edge.
- Write bypass: wb_we=1, wb_addr=5, wb_data=32'hDEADBEEF, instruction rs=5 → id_ex_rs_data=32'hDEADBEEF next cycle. A write to r0 leaves r0 reading 0.
- Load-use: ex_mem_read=1, ex_rd=3, instruction ADD using rt=3 → stall=1 for one cycle, id_ex_valid=0. Next cycle (ex_mem_read=0) → id_ex_valid=1.
- BEQ taken with wrap: r1=r2=7, pc_plus4=32'hFFFF_FFFC, imm=16'h0001 → branch_taken=1, branch_target=32'h0000_0000. BNE with the same operands gives branch_taken=0.
- Branch-on-MEM: mem_we=1, mem_rd=4, mem_data=9, BEQ rs=4 against rt=r6=9 → with BRANCH_FWD_EN: stall=0, taken=1. Without it: stall=1, taken=0.
- Flush plus stall: id_flush=1 with a load-use condition → stall=1, id_ex_valid=0, branch_taken=0.
